tick_scheduler: RTL

Multi-channel clock-enable scheduler that generates CH independent divided clocks and single-cycle tick strobes from one system clock. Each channel is a programmable half-period divider, so a divider ratio of DIV gives toggling every DIV/2 cycles. A single config port reprograms or enables/disables one channel at a time. Each change is applied glitch-free at the end of that channel's high phase. It sits between the board clock and the display/scan/timer logic that needs slow clocks or enables.

---
 rtl/tick_scheduler_if.sv | 29 ++
 rtl/tick_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : tick_scheduler_if
//  Purpose  : Config request bundle for tick_scheduler. The master issues
//             one channel reprogram request at a time, and the slave
//             (the scheduler) reports ready and bad-channel errors.
//  Revision : 1.0  initial release
// ============================================================================
interface tick_scheduler_if #(
    parameter int CNT_W = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_en;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_en,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_en,
        output cfg_ready, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tick_scheduler
//  Purpose  : CH independent half-period clock dividers with per-channel
//             rising-edge tick strobes. A config request is held pending and
//             applied at the end of the target channel's high phase, or at
//             once if that channel is disabled, so the divided clock never
//             glitches.
//  Options  : TICK_SCHED_SYNC_EN adds the sync_all input. It realigns all
//             enabled channels and forces any pending config to apply.
//  Revision : 1.0  initial release
// ============================================================================
module tick_scheduler #(
    parameter int CH          = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 20
) (
    input  logic          I_CLK,
    input  logic          Rst,
`ifdef TICK_SCHED_SYNC_EN
    input  logic          sync_all,
`endif
    tick_scheduler_if.slave cfg,
    output logic [CH-1:0] O_CLK,
    output logic [CH-1:0] tick,
    output logic          busy
);

    localparam logic [3:0]       CH_LIM  = 4'(CH);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_q;
    logic             ready_q;
    logic             err_q;
    logic             busy_q;
    logic [2:0]       pend_ch_q;
    logic [CNT_W-1:0] pend_div_q;
    logic             pend_en_q;

    logic [CH-1:0]    apply_hit;
    logic             apply_any;
    logic             sync_w;

`ifdef TICK_SCHED_SYNC_EN
    assign sync_w = sync_all;
`else
    assign sync_w = 1'b0;
`endif

    assign apply_any     = |apply_hit;
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;
    assign busy          = busy_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic             en_q, en_d;
        logic             o_clk_q, o_clk_d;
        logic             tick_q, tick_d;
        logic [CNT_W-1:0] half_w;
        logic             at_end_w;

        // Half period; clamped so divisors 0, 1 and 2 all toggle every cycle
        always_comb begin
            half_w = div_q >> 1;
            if (half_w == '0) begin
                half_w = ONE;
            end
        end

        assign at_end_w = (cnt_q == half_w - ONE);

        // Pending config lands here when disabled or at the end of the high phase
        assign apply_hit[i] = (state_q == ST_WAIT) && (pend_ch_q == 3'(i)) &&
                              (!en_q || (o_clk_q && at_end_w) || sync_w);

        // Divider next state: apply > realign > disabled > normal count
        always_comb begin
            cnt_d   = cnt_q;
            div_d   = div_q;
            en_d    = en_q;
            o_clk_d = o_clk_q;
            tick_d  = 1'b0;
            if (apply_hit[i]) begin
                div_d   = pend_div_q;
                en_d    = pend_en_q;
                cnt_d   = '0;
                o_clk_d = 1'b0;
            end else if (sync_w || !en_q) begin
                cnt_d   = '0;
                o_clk_d = 1'b0;
            end else if (at_end_w) begin
                cnt_d   = '0;
                o_clk_d = ~o_clk_q;
                tick_d  = ~o_clk_q;
            end else begin
                cnt_d   = cnt_q + ONE;
            end
        end

        // Divider state registers
        always_ff @(posedge I_CLK) begin
            if (Rst) begin
                cnt_q   <= '0;
                div_q   <= DIV_RST;
                en_q    <= 1'b1;
                o_clk_q <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                div_q   <= div_d;
                en_q    <= en_d;
                o_clk_q <= o_clk_d;
                tick_q  <= tick_d;
            end
        end

        assign O_CLK[i] = o_clk_q;
        assign tick[i]  = tick_q;
    end

    // Config FSM: accept in IDLE, hold in WAIT until the target channel applies
    always_ff @(posedge I_CLK) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            pend_ch_q  <= '0;
            pend_div_q <= '0;
            pend_en_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg.cfg_valid && ready_q) begin
                        pend_ch_q  <= cfg.cfg_ch;
                        pend_div_q <= cfg.cfg_div;
                        pend_en_q  <= cfg.cfg_en;
                        if ({1'b0, cfg.cfg_ch} >= CH_LIM) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (apply_any) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
